// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses onto a word-only dmem, read-modify-write for sub-word stores.
// Define LSU_SYNC_RD_EN when dmem has a synchronous read port (adds the RWAIT state).
`timescale 1ns/1ps
module lsu #(
  parameter int unsigned AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
`ifdef LSU_SYNC_RD_EN
    RWAIT = 3'd2,
`endif
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            we_q, uns_q;
  logic [1:0]      size_q, off_q;
  logic [HW-1:0]   wdata_q;
  logic            req_bad;
  logic            sample_c;
  logic            mem_re_d, mem_we_d, rsp_valid_d, rsp_err_d;
  logic [DW-1:0]   mem_wdata_d, rsp_rdata_d;
  logic            unused_addr_hi;

  // Upper address bits alias in memory by design
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_ready = (state_q == IDLE);

`ifdef LSU_SYNC_RD_EN
  assign sample_c = (state_q == RWAIT);
`else
  assign sample_c = (state_q == READ);
`endif

  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
    logic [7:0]    b;
    logic [HW-1:0] h;
    logic [DW-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [HW-1:0] wd);
    logic [DW-1:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && req_size == 2'b10) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d  = READ;
            mem_re_d = 1'b1;
          end
        end
      end
      READ: begin
`ifdef LSU_SYNC_RD_EN
        state_d = RWAIT;
`endif
      end
`ifdef LSU_SYNC_RD_EN
      RWAIT: ;
`endif
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Read data lands: finish a load or merge a sub-word store
    if (sample_c) begin
      if (we_q) begin
        state_d     = WRITE;
        mem_we_d    = 1'b1;
        mem_wdata_d = store_merge(mem_rdata, size_q, off_q, wdata_q);
      end else begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext(mem_rdata, size_q, uns_q, off_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (req_valid && state_q == IDLE) begin
        we_q     <= req_we;
        uns_q    <= req_unsigned;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata[HW-1:0];
        mem_addr <= DW'(req_addr[AW+1:2]);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a word-wide dmem model; latencies follow LSU_SYNC_RD_EN.
`timescale 1ns/1ps
module tb_lsu;

  localparam int unsigned AW = 8;
`ifdef LSU_SYNC_RD_EN
  localparam int LAT_LD  = 3;
  localparam int LAT_SUB = 4;
`else
  localparam int LAT_LD  = 2;
  localparam int LAT_SUB = 3;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] dmem [0:255];

  lsu #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem model
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
`ifdef LSU_SYNC_RD_EN
  always @(posedge clk) if (mem_re) mem_rdata <= dmem[mem_addr[7:0]];
`else
  assign mem_rdata = dmem[mem_addr[7:0]];
`endif

  int n_chk = 0;
  int n_err = 0;
  int viol  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output invariants sampled every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_re && mem_we) viol++;
      if (!mem_we && mem_wdata != 32'h0) viol++;
      if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) viol++;
    end
  end

  int          o_lat, o_nre, o_nwe;
  logic [31:0] o_rd, o_waddr, o_wdata, o_raddr;
  logic        o_err;

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    logic done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 0; o_nre = 0; o_nwe = 0; o_rd = 32'hx; o_err = 1'bx;
    o_waddr = 32'hx; o_wdata = 32'hx; o_raddr = 32'hx;
    done = 1'b0;
    for (int i = 1; i <= 12 && !done; i++) begin
      @(negedge clk);
      if (mem_re) begin o_nre++; o_raddr = mem_addr; end
      if (mem_we) begin o_nwe++; o_waddr = mem_addr; o_wdata = mem_wdata; end
      if (rsp_valid) begin o_lat = i; o_rd = rsp_rdata; o_err = rsp_err; done = 1'b1; end
    end
    check("rsp_timeout", 32'(done), 32'h1);
  endtask

  task automatic do_ld(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] exp);
    xact(1'b0, sz, uns, a, 32'h0);
    check({tag, "_data"}, o_rd, exp);
    check({tag, "_lat"}, 32'(o_lat), 32'(LAT_LD));
    check({tag, "_err"}, 32'(o_err), 32'h0);
  endtask

  task automatic do_st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_w, input int lat, input int nre);
    xact(1'b1, sz, 1'b0, a, wd);
    check({tag, "_wdata"}, o_wdata, exp_w);
    check({tag, "_waddr"}, o_waddr, {24'h0, a[9:2]});
    check({tag, "_lat"}, 32'(o_lat), 32'(lat));
    check({tag, "_nwe"}, 32'(o_nwe), 32'h1);
    check({tag, "_nre"}, 32'(o_nre), 32'(nre));
    check({tag, "_rdata"}, o_rd, 32'h0);
    check({tag, "_err"}, 32'(o_err), 32'h0);
  endtask

  task automatic do_bad(input string tag, input logic we, input logic [1:0] sz, input logic [31:0] a);
    xact(we, sz, 1'b0, a, 32'h5555AAAA);
    check({tag, "_err"}, 32'(o_err), 32'h1);
    check({tag, "_lat"}, 32'(o_lat), 32'h1);
    check({tag, "_rdata"}, o_rd, 32'h0);
    check({tag, "_memacc"}, 32'(o_nre + o_nwe), 32'h0);
  endtask

  logic        bw [3];
  logic [1:0]  bs [3];
  logic [31:0] ba [3];
  logic [31:0] bd [3];

  task automatic set_req(input int i);
    req_we = bw[i]; req_size = bs[i]; req_unsigned = 1'b0;
    req_addr = ba[i]; req_wdata = bd[i];
  endtask

  initial begin
    int acc [3];
    int rc [4];
    logic [31:0] rd [4];
    int idx, nr, busy, cnt;
    logic took;

    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_strobes", {28'h0, rsp_valid, rsp_err, mem_re, mem_we}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // Word store and sub-word loads
    do_st("sw04", 2'b10, 32'h04, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0);
    do_ld("lb07", 2'b00, 1'b0, 32'h07, 32'hFFFFFFDE);
    do_ld("lbu07", 2'b00, 1'b1, 32'h07, 32'h000000DE);
    do_ld("lb04", 2'b00, 1'b0, 32'h04, 32'hFFFFFFEF);
    do_ld("lh04", 2'b01, 1'b0, 32'h04, 32'hFFFFBEEF);
    do_ld("lhu06", 2'b01, 1'b1, 32'h06, 32'h0000DEAD);
    check("lhu06_raddr", o_raddr, 32'h1);

    // Read-modify-write stores
    do_st("sh06", 2'b01, 32'h06, 32'h00001234, 32'h1234BEEF, LAT_SUB, 1);
    do_st("sb04", 2'b00, 32'h04, 32'h000000AA, 32'h1234BEAA, LAT_SUB, 1);
    do_ld("lw04", 2'b10, 1'b0, 32'h04, 32'h1234BEAA);

    // Error responses leave memory untouched
    do_bad("lw02", 1'b0, 2'b10, 32'h02);
    do_bad("sh05", 1'b1, 2'b01, 32'h05);
    do_bad("sz11", 1'b1, 2'b11, 32'h04);
    do_ld("lw04_after_err", 2'b10, 1'b0, 32'h04, 32'h1234BEAA);

    // High address bits alias onto word 1
    do_ld("lw404_alias", 2'b10, 1'b0, 32'h00000404, 32'h1234BEAA);
    check("alias_raddr", o_raddr, 32'h1);

    // Back-to-back with req_valid held: LW, SW, LB
    bw[0] = 1'b0; bs[0] = 2'b10; ba[0] = 32'h04; bd[0] = 32'h0;
    bw[1] = 1'b1; bs[1] = 2'b10; ba[1] = 32'h08; bd[1] = 32'hCAFEF00D;
    bw[2] = 1'b0; bs[2] = 2'b00; ba[2] = 32'h0B; bd[2] = 32'h0;
    foreach (acc[i]) acc[i] = -100;
    foreach (rc[i]) begin rc[i] = -100; rd[i] = 32'h0; end
    idx = 0; nr = 0; busy = 0;
    @(negedge clk);
    set_req(0); req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid && nr < 4) begin rc[nr] = c; rd[nr] = rsp_rdata; nr++; end
      took = 1'b0;
      if (idx < 3) begin
        if (req_ready) begin acc[idx] = c; took = 1'b1; end
        else busy++;
      end
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 3) set_req(idx);
        else req_valid = 1'b0;
      end
    end
    check("b2b_accepted", 32'(idx), 32'h3);
    check("b2b_nrsp", 32'(nr), 32'h3);
    check("b2b_busy", 32'(busy), 32'(LAT_LD + 2));
    check("b2b_gap01", 32'(acc[1] - acc[0]), 32'(LAT_LD + 1));
    check("b2b_gap12", 32'(acc[2] - acc[1]), 32'h3);
    check("b2b_lat0", 32'(rc[0] - acc[0]), 32'(LAT_LD));
    check("b2b_lat1", 32'(rc[1] - acc[1]), 32'h2);
    check("b2b_lat2", 32'(rc[2] - acc[2]), 32'(LAT_LD));
    check("b2b_lw", rd[0], 32'h1234BEAA);
    check("b2b_sw", rd[1], 32'h0);
    check("b2b_lb", rd[2], 32'hFFFFFFCA);
    do_ld("lw08", 2'b10, 1'b0, 32'h08, 32'hCAFEF00D);

    // Reset pulse during the READ of a sub-word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h04; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_re_before", 32'(mem_re), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_re_drop", 32'(mem_re), 32'h0);
    check("rst_mid_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || mem_we || mem_re) cnt++;
      if (!req_ready) cnt++;
    end
    check("rst_mid_quiet", 32'(cnt), 32'h0);
    do_ld("lw04_after_rst", 2'b10, 1'b0, 32'h04, 32'h1234BEAA);

    check("invariants", 32'(viol), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
